opll_write_sequencer: RTL and testbench

//  Queues host register writes (addr,data) and replays them onto the OPLL CPU bus
//  (DIN, A0, CS_n, WR_n) with the chip's mandatory timing. Two bus strobes per write:

---
 rtl/opll_write_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_opll_write_sequencer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/opll_write_sequencer.sv
// Buffers host (addr,data) register writes and replays each one onto the OPLL CPU bus
// as an address strobe then a data strobe, each followed by a phiM-timed recovery wait.
module opll_write_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int STROBE_LEN = 2,
  parameter int ADDR_WAIT  = 12,
  parameter int DATA_WAIT  = 84
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              phim_cen,
  input  logic                              flush,
  input  logic                              req_valid,
  input  logic [7:0]                        req_addr,
  input  logic [7:0]                        req_data,
  output logic                              req_ready,
  output logic [7:0]                        opll_din,
  output logic                              opll_a0,
  output logic                              opll_cs_n,
  output logic                              opll_wr_n,
  output logic                              busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);

  localparam int CW   = $clog2(FIFO_DEPTH + 1);
  localparam int PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int MAXW = (ADDR_WAIT > DATA_WAIT) ? ADDR_WAIT : DATA_WAIT;
  localparam int MAXN = (MAXW > STROBE_LEN) ? MAXW : STROBE_LEN;
  localparam int TW   = (MAXN > 1) ? $clog2(MAXN) : 1;

  localparam logic [TW-1:0] STB_LD   = TW'(STROBE_LEN - 1);
  localparam logic [TW-1:0] AWAIT_LD = TW'(ADDR_WAIT - 1);
  localparam logic [TW-1:0] DWAIT_LD = TW'(DATA_WAIT - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ADDR_STB  = 3'd1,
    S_ADDR_WAIT = 3'd2,
    S_DATA_STB  = 3'd3,
    S_DATA_WAIT = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [7:0]      addr_q, addr_d, data_q, data_d;
  logic [7:0]      din_q, din_d;
  logic            a0_q, a0_d, cs_n_q, cs_n_d, wr_n_q, wr_n_d;
  logic [7:0]      mem_addr_q [FIFO_DEPTH];
  logic [7:0]      mem_data_q [FIFO_DEPTH];
  logic            push_s, pop_s, cnt_zero_s;
  logic [TW-1:0]   cnt_dec_s;

  assign req_ready  = (count_q < DEPTH_C);
  assign push_s     = req_valid & req_ready & ~flush;
  assign cnt_zero_s = (cnt_q == '0);
  assign cnt_dec_s  = phim_cen ? (cnt_q - TW'(1)) : cnt_q;

  // Sequencer: each timed state ends on the phiM tick that finds cnt at zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    pop_s   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if ((count_q != '0) && !flush) pop_s = 1'b1;
        else                           pop_s = 1'b0;
      end
      S_ADDR_STB: begin
        if (phim_cen && cnt_zero_s) begin state_d = S_ADDR_WAIT; cnt_d = AWAIT_LD; end
        else                        cnt_d = cnt_dec_s;
      end
      S_ADDR_WAIT: begin
        if (phim_cen && cnt_zero_s) begin state_d = S_DATA_STB; cnt_d = STB_LD; end
        else                        cnt_d = cnt_dec_s;
      end
      S_DATA_STB: begin
        if (phim_cen && cnt_zero_s) begin state_d = S_DATA_WAIT; cnt_d = DWAIT_LD; end
        else                        cnt_d = cnt_dec_s;
      end
      S_DATA_WAIT: begin
        if (phim_cen && cnt_zero_s) begin
          if ((count_q != '0) && !flush) pop_s   = 1'b1;
          else                           state_d = S_IDLE;
        end else begin
          cnt_d = cnt_dec_s;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    if (pop_s) begin
      state_d = S_ADDR_STB;
      cnt_d   = STB_LD;
      addr_d  = mem_addr_q[rd_ptr_q];
      data_d  = mem_data_q[rd_ptr_q];
    end else begin
      addr_d  = addr_q;
      data_d  = data_q;
    end
  end

  // FIFO bookkeeping; flush wins over a same-cycle push.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_ptr_d = push_s ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
      rd_ptr_d = pop_s  ? (rd_ptr_q + PW'(1)) : rd_ptr_q;
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Bus drive follows the state being entered; din/a0 hold between strobes for margin.
  always_comb begin
    din_d  = din_q;
    a0_d   = a0_q;
    cs_n_d = 1'b1;
    wr_n_d = 1'b1;
    case (state_d)
      S_ADDR_STB: begin din_d = addr_d; a0_d = 1'b0; cs_n_d = 1'b0; wr_n_d = 1'b0; end
      S_DATA_STB: begin din_d = data_d; a0_d = 1'b1; cs_n_d = 1'b0; wr_n_d = 1'b0; end
      default:    begin din_d = din_q;  a0_d = a0_q; cs_n_d = 1'b1; wr_n_d = 1'b1; end
    endcase
  end

  // State, counters and registered bus outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      addr_q   <= 8'h00;
      data_q   <= 8'h00;
      din_q    <= 8'h00;
      a0_q     <= 1'b0;
      cs_n_q   <= 1'b1;
      wr_n_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      din_q    <= din_d;
      a0_q     <= a0_d;
      cs_n_q   <= cs_n_d;
      wr_n_q   <= wr_n_d;
    end
  end

  // Request storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_addr_q[i] <= 8'h00;
        mem_data_q[i] <= 8'h00;
      end
    end else if (push_s) begin
      mem_addr_q[wr_ptr_q] <= req_addr;
      mem_data_q[wr_ptr_q] <= req_data;
    end
  end

  assign opll_din   = din_q;
  assign opll_a0    = a0_q;
  assign opll_cs_n  = cs_n_q;
  assign opll_wr_n  = wr_n_q;
  assign busy       = (state_q != S_IDLE) || (count_q != '0);
  assign fifo_count = count_q;

endmodule

// File: tb/tb_opll_write_sequencer.sv
// Directed bench for opll_write_sequencer: bus strobe timing, phiM scaling, FIFO full/flush, reset abort.
module tb_opll_write_sequencer;

  logic       clk = 1'b0;
  logic       rst_n, phim_cen, flush, req_valid;
  logic [7:0] req_addr, req_data;
  logic       req_ready, opll_a0, opll_cs_n, opll_wr_n, busy;
  logic [7:0] opll_din;
  logic [2:0] fifo_count;

  opll_write_sequencer dut (
    .clk(clk), .rst_n(rst_n), .phim_cen(phim_cen), .flush(flush),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready), .opll_din(opll_din), .opll_a0(opll_a0),
    .opll_cs_n(opll_cs_n), .opll_wr_n(opll_wr_n), .busy(busy), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;
  int cyc = 0;
  int last_acc = 0;
  bit cen_div = 1'b0;

  // cyc counts rising edges; at a falling edge it equals the index of the edge just taken.
  always @(posedge clk) cyc <= cyc + 1;

  // In divided mode phim_cen is high only at edges whose index is 1 mod 4.
  always @(negedge clk) phim_cen = cen_div ? (cyc % 4 == 0) : 1'b1;

  // Bus event log sampled mid-cycle.
  int         fall_cyc[$], rise_cyc[$];
  logic [7:0] fall_din[$];
  logic       fall_a0[$];
  int         busy_fall = -1;
  int         wr_cs_bad = 0;
  logic       cs_prev = 1'b1, busy_prev = 1'b0;

  always @(negedge clk) begin
    if (opll_cs_n !== opll_wr_n) wr_cs_bad++;
    if (cs_prev && !opll_cs_n) begin
      fall_cyc.push_back(cyc);
      fall_din.push_back(opll_din);
      fall_a0.push_back(opll_a0);
    end
    if (!cs_prev && opll_cs_n) rise_cyc.push_back(cyc);
    if (busy_prev && !busy) busy_fall = cyc;
    cs_prev   = opll_cs_n;
    busy_prev = busy;
  end

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic clear_log();
    fall_cyc.delete(); rise_cyc.delete(); fall_din.delete(); fall_a0.delete();
    busy_fall = -1;
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic push(input logic [7:0] a, input logic [7:0] d);
    int n = 0;
    while (req_ready !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
    expect_eq("push_ready", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_addr = a; req_data = d;
    @(posedge clk); #1 last_acc = cyc;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input int maxc);
    int n = 0;
    @(negedge clk);
    while (busy !== 1'b0 && n < maxc) begin @(negedge clk); n++; end
    expect_eq("idle_timeout", {31'd0, busy}, 32'd0);
    #1;
  endtask

  task automatic sync_clear();
    @(posedge clk); #1 clear_log();
    @(negedge clk);
  endtask

  int e;

  initial begin
    rst_n = 1'b1; phim_cen = 1'b1; flush = 1'b0; req_valid = 1'b0;
    req_addr = 8'h00; req_data = 8'h00;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    expect_eq("rst_cs_n", {31'd0, opll_cs_n}, 32'd1);
    expect_eq("rst_wr_n", {31'd0, opll_wr_n}, 32'd1);
    expect_eq("rst_din", {24'd0, opll_din}, 32'd0);
    expect_eq("rst_a0", {31'd0, opll_a0}, 32'd0);
    expect_eq("rst_busy", {31'd0, busy}, 32'd0);
    expect_eq("rst_count", {29'd0, fifo_count}, 32'd0);
    expect_eq("rst_ready", {31'd0, req_ready}, 32'd1);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Single write at full phiM rate.
    sync_clear();
    push(8'h10, 8'h55);
    e = last_acc;
    wait_idle(300);
    expect_eq("t1_nfall", fall_cyc.size(), 32'd2);
    expect_eq("t1_astb_start", fall_cyc[0] - e, 32'd1);
    expect_eq("t1_astb_a0", {31'd0, fall_a0[0]}, 32'd0);
    expect_eq("t1_astb_din", {24'd0, fall_din[0]}, 32'h10);
    expect_eq("t1_astb_end", rise_cyc[0] - e, 32'd3);
    expect_eq("t1_dstb_start", fall_cyc[1] - e, 32'd15);
    expect_eq("t1_dstb_a0", {31'd0, fall_a0[1]}, 32'd1);
    expect_eq("t1_dstb_din", {24'd0, fall_din[1]}, 32'h55);
    expect_eq("t1_dstb_end", rise_cyc[1] - e, 32'd17);
    expect_eq("t1_busy_fall", busy_fall - e, 32'd101);

    // phiM at clk/4: every duration scales by four.
    @(posedge clk); #1 clear_log(); cen_div = 1'b1;
    @(negedge clk);
    while (cyc % 4 != 3) @(negedge clk);
    push(8'h20, 8'hAA);
    e = last_acc;
    wait_idle(600);
    expect_eq("t2_nfall", fall_cyc.size(), 32'd2);
    expect_eq("t2_astb_start", fall_cyc[0] - e, 32'd1);
    expect_eq("t2_astb_end", rise_cyc[0] - e, 32'd9);
    expect_eq("t2_dstb_start", fall_cyc[1] - e, 32'd57);
    expect_eq("t2_dstb_din", {24'd0, fall_din[1]}, 32'hAA);
    expect_eq("t2_dstb_end", rise_cyc[1] - e, 32'd65);
    expect_eq("t2_busy_fall", busy_fall - e, 32'd401);
    @(posedge clk); #1 cen_div = 1'b0;

    // Six back-to-back writes: queue fills, refills on the next pop, order preserved.
    sync_clear();
    push(8'h30, 8'hA0);
    e = last_acc;
    push(8'h31, 8'hA1);
    expect_eq("t3_pushpop_count", {29'd0, fifo_count}, 32'd1);
    push(8'h32, 8'hA2);
    push(8'h33, 8'hA3);
    push(8'h34, 8'hA4);
    expect_eq("t3_full_count", {29'd0, fifo_count}, 32'd4);
    expect_eq("t3_full_ready", {31'd0, req_ready}, 32'd0);
    push(8'h35, 8'hA5);
    expect_eq("t3_refill_acc", last_acc - e, 32'd102);
    expect_eq("t3_refill_count", {29'd0, fifo_count}, 32'd4);
    wait_idle(800);
    expect_eq("t3_nfall", fall_cyc.size(), 32'd12);
    for (int k = 0; k < 6; k++) begin
      expect_eq($sformatf("t3_w%0d_time", k), fall_cyc[2*k] - e, 32'(1 + 100*k));
      expect_eq($sformatf("t3_w%0d_addr", k), {24'd0, fall_din[2*k]}, 32'(8'h30 + k));
      expect_eq($sformatf("t3_w%0d_data", k), {24'd0, fall_din[2*k+1]}, 32'(8'hA0 + k));
    end
    expect_eq("t3_busy_fall", busy_fall - e, 32'd601);

    // Flush with one write in flight and three queued.
    sync_clear();
    push(8'h50, 8'h60);
    e = last_acc;
    push(8'h51, 8'h61);
    push(8'h52, 8'h62);
    push(8'h53, 8'h63);
    expect_eq("t4_pre_count", {29'd0, fifo_count}, 32'd3);
    flush = 1'b1; req_valid = 1'b1; req_addr = 8'h99; req_data = 8'h98;
    @(negedge clk);
    flush = 1'b0; req_valid = 1'b0;
    expect_eq("t4_post_count", {29'd0, fifo_count}, 32'd0);
    expect_eq("t4_post_busy", {31'd0, busy}, 32'd1);
    wait_idle(300);
    expect_eq("t4_nfall", fall_cyc.size(), 32'd2);
    expect_eq("t4_addr", {24'd0, fall_din[0]}, 32'h50);
    expect_eq("t4_data", {24'd0, fall_din[1]}, 32'h60);
    expect_eq("t4_busy_fall", busy_fall - e, 32'd101);

    // Reset asserted during the data strobe aborts at once and leaves nothing queued.
    sync_clear();
    push(8'h44, 8'h66);
    push(8'h45, 8'h67);
    begin
      int n = 0;
      while (!(opll_cs_n === 1'b0 && opll_a0 === 1'b1) && n < 100) begin @(negedge clk); n++; end
      expect_eq("t5_reach_dstb", {31'd0, opll_a0 & ~opll_cs_n}, 32'd1);
    end
    rst_n = 1'b0;
    #1;
    expect_eq("t5_cs_n", {31'd0, opll_cs_n}, 32'd1);
    expect_eq("t5_wr_n", {31'd0, opll_wr_n}, 32'd1);
    expect_eq("t5_count", {29'd0, fifo_count}, 32'd0);
    expect_eq("t5_busy", {31'd0, busy}, 32'd0);
    expect_eq("t5_din", {24'd0, opll_din}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    sync_clear();
    repeat (150) @(negedge clk);
    expect_eq("t5_no_activity", fall_cyc.size(), 32'd0);
    expect_eq("t5_idle", {31'd0, busy}, 32'd0);

    expect_eq("wr_n_tracks_cs_n", wr_cs_bad, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
